// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared widths, station tags and idle-bus value for the Tomasulo datapath
package tomasulo_pkg;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam logic [DATA_W-1:0] SEM_VALOR = 16'hFFF0;
  localparam logic [DATA_W-1:0] IDLE_DATA = SEM_VALOR;
  typedef enum logic [TAG_W-1:0] {
    FREE_REGISTER,
    RES_STATION_ADD1,
    RES_STATION_ADD2,
    RES_STATION_ADD3,
    RES_STATION_MUL1,
    RES_STATION_MUL2,
    RES_STATION_LOAD1,
    RES_STATION_LOAD2,
    RES_STATION_STORE1
  } station_tag_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating priority encoder, first set req bit searching ptr, ptr+1, ... modulo N
//   req   - request vector
//   ptr   - index searched first
//   found - any request set
//   idx   - winning index (0 when none found)
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);
  always_comb begin
    int j;
    found = |req;
    idx = '0;
    j = 0;
    // descending so the nearest position to ptr is assigned last and wins
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j[PW-1:0]]) idx = j[PW-1:0];
    end
  end
endmodule

// File: rtl/cdb_rr_scheduler.sv
// cdb_rr_scheduler: round-robin CDB arbiter with aging override and registered one-cycle grant
//   clk, rst_n  - clock, asynchronous active-low reset
//   done        - per-unit result-ready flags
//   q_flat      - per-unit results, slice i at [i*DATA_W +: DATA_W]
//   hold        - suppress any new grant this cycle
//   grant       - one-hot registered grant pulse
//   cdb_valid   - broadcast valid this cycle
//   qi_cdb      - winning station tag (unit index + 1), 0 when idle
//   qi_cdb_data - winning result, IDLE_DATA when idle
module cdb_rr_scheduler
  import tomasulo_pkg::*;
#(
  parameter int N_UF     = 4,
  parameter int DATA_W   = tomasulo_pkg::DATA_W,
  parameter int TAG_W    = tomasulo_pkg::TAG_W,
  parameter int AGE_W    = 3,
  parameter int MAX_WAIT = 6,
  parameter logic [DATA_W-1:0] IDLE_DATA = DATA_W'(tomasulo_pkg::SEM_VALOR)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_UF-1:0]          done,
  input  logic [N_UF*DATA_W-1:0]   q_flat,
  input  logic                     hold,
  output logic [N_UF-1:0]          grant,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         qi_cdb,
  output logic [DATA_W-1:0]        qi_cdb_data
);
  localparam int PW = $clog2(N_UF);
  logic [DATA_W-1:0] q [N_UF];
  logic [AGE_W-1:0] age [N_UF];
  logic [PW-1:0] ptr, rr_idx, aged_idx, win_idx;
  logic [N_UF-1:0] eligible, aged;
  logic rr_found, aged_found, win;
  for (genvar i = 0; i < N_UF; i++) begin : g_q
    assign q[i] = q_flat[i*DATA_W +: DATA_W];
  end
  // a unit granted last cycle is still dropping done, so it is masked out
  assign eligible = done & ~grant;
  always_comb begin
    aged = '0;
    for (int i = 0; i < N_UF; i++) aged[i] = eligible[i] && (age[i] >= AGE_W'(MAX_WAIT));
  end
  rr_pick #(.N(N_UF), .PW(PW)) u_rr_pick (
    .req(eligible), .ptr(ptr), .found(rr_found), .idx(rr_idx)
  );
  rr_pick #(.N(N_UF), .PW(PW)) u_aged_pick (
    .req(aged), .ptr('0), .found(aged_found), .idx(aged_idx)
  );
  assign win = ~hold & rr_found;
  assign win_idx = aged_found ? aged_idx : rr_idx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      cdb_valid <= 1'b0;
      qi_cdb <= FREE_REGISTER;
      qi_cdb_data <= IDLE_DATA;
      ptr <= '0;
      for (int i = 0; i < N_UF; i++) age[i] <= '0;
    end else begin
      grant <= win ? N_UF'(1) << win_idx : '0;
      cdb_valid <= win;
      qi_cdb <= win ? TAG_W'(win_idx) + 1'b1 : FREE_REGISTER;
      qi_cdb_data <= win ? q[win_idx] : IDLE_DATA;
      if (win) ptr <= (int'(win_idx) == N_UF - 1) ? '0 : win_idx + 1'b1;
      for (int i = 0; i < N_UF; i++)
        age[i] <= (!done[i] || (win && win_idx == PW'(i))) ? '0 :
                  (eligible[i] && age[i] != '1) ? age[i] + 1'b1 : age[i];
    end
  end
endmodule

// File: doc/cdb_rr_scheduler.md
Name: cdb_rr_scheduler

Overview:
- Decides which functional unit drives the common data bus (CDB) each cycle.
- Sits between the functional units (each raises Done with a 16-bit result Q) and the CDB consumers: register status, reservation stations and selectors.
- Arbitration is round-robin with an aging override. The output is registered, and a one-cycle Grant pulse releases the winning unit.

Parameters:
- N_UF, 4: number of requesting functional units (2 to 8).
- DATA_W, 16: result width.
- TAG_W, 4: CDB tag width; unit i broadcasts tag i+1, and tag 0 means "no station".
- AGE_W, 3: width of the per-requester wait counter.
- MAX_WAIT, 6: a requester whose age has reached this value wins over the round-robin order (must be ≤ 2^AGE_W-1).
- IDLE_DATA, 16'hFFF0: value driven on the data bus when no broadcast is in progress.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Done  in  N_UF  bit i high means unit i holds a finished result; held high until Grant[i] is seen.
- Q_flat  in  N_UF*DATA_W  results; slice i is bits [i*DATA_W +: DATA_W], stable while Done[i] is high.
- Hold  in  1  freeze the CDB: no new grant this cycle.
- Grant  out  N_UF  one-hot, registered, one-cycle pulse to the winner.
- Cdb_valid  out  1  a broadcast is valid this cycle.
- Qi_CDB  out  TAG_W  winning station tag (i+1), or 0 when idle.
- Qi_CDB_data  out  DATA_W  winning result, or IDLE_DATA when idle.

Behaviour:
- Reset low (asynchronous): Grant=0, Cdb_valid=0, Qi_CDB=0, Qi_CDB_data=IDLE_DATA, pointer ptr=0, all age counters=0. Outputs stay there while Reset is low; normal operation resumes on the first edge after release.
- Eligibility: eligible[i] = Done[i] & ~Grant[i]. The mask stops a double grant while the unit is dropping Done.
- Winner selection (combinational, evaluated at each edge):
  - If Hold=1, or no requester is eligible, there is no winner.
  - Otherwise, if any eligible requester has age ≥ MAX_WAIT, the lowest-index such requester wins.
  - Otherwise the first eligible index searching ptr, ptr+1, … wraps modulo N_UF.
- Edge with winner w:
  - Grant=onehot(w), Cdb_valid=1, Qi_CDB=w+1, Qi_CDB_data=Q slice w.
  - ptr ← (w+1) mod N_UF; age[w] ← 0.
- Edge with no winner: Grant=0, Cdb_valid=0, Qi_CDB=0, Qi_CDB_data=IDLE_DATA; ptr unchanged.
- Latency: Done rising before edge t gives a broadcast in the cycle after edge t at the earliest (1 cycle). The broadcast lasts exactly 1 cycle.
- Age counters, for each i other than the winner:
  - Eligible and not granted: age[i] increments, saturating at 2^AGE_W-1. Hold cycles count.
  - Done[i]=0: age[i] ← 0.
- Requester contract: after seeing Grant[i]=1, the unit deasserts Done[i] before the next edge, or re-asserts it with a new result. The arbiter does not check this.
- Hold asserted while a broadcast is in progress: the current broadcast still completes its single cycle, and the next cycle is idle.
- Throughput: at most one broadcast per cycle; back-to-back grants to different units are allowed. With N_UF requesters continuously active, each unit is served within N_UF cycles.
- Reset asserted mid-broadcast: outputs clear immediately (asynchronously). A lost grant is re-requested because Done is still high.

Decomposition:
- Shared package tomasulo_pkg holds:
  - Station tag constants (FREE_REGISTER=0, RES_STATION_ADD1=1, RES_STATION_ADD2=2, …).
  - sem_valor / IDLE_DATA.
  - DATA_W and TAG_W.
- One sub-module, rr_pick: a combinational rotating priority encoder with inputs req[N_UF] and ptr, and outputs found and idx. It is instantiated twice:
  - once for the round-robin pick, using ptr;
  - once for the aged pick, using ptr=0.

Test Plan:
- Reset: drive Reset=0 mid-simulation with Done=4'b1111 → outputs go to 0/0/0/16'hFFF0 immediately. Release → first grant goes to unit 0 (Qi_CDB=1).
- Single request: Done[1]=1, Q1=16'h0025 → in the next cycle Grant=4'b0010, Qi_CDB=2, Qi_CDB_data=16'h0025, Cdb_valid=1. Unit drops Done → following cycle is idle with data 16'hFFF0.
- Round-robin: all four Done held high and re-asserted after each grant → tags follow 1,2,3,4,1,… with no repeats and no idle cycles.
- Grant mask: unit 2 keeps Done high for one extra cycle after its grant → no second grant to unit 2 in that cycle.
- Aging: hold Hold=1 for 7 cycles with Done=4'b1001 and ptr=0, release Hold → unit 0 wins (aged, lowest index), then unit 3. Repeat with only unit 3 aged and ptr=0 → unit 3 wins first.
- Hold: Done[0]=1 with Hold=1 for 3 cycles → Cdb_valid stays 0. Hold falls → broadcast of tag 1 in the next cycle.
